// File: rtl/subtractor_64_mc.sv
// Multi-cycle A - B (as A + ~B + 1), one SLICE-bit chunk per clock, with ARM NZCV flags.
// Optional ADD_MODE_EN adds an 'op' port (1 = subtract, 0 = add) sampled with start.
module subtractor_64_mc #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef ADD_MODE_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_cfg
            $error("WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic             zacc;
    logic [IW-1:0]    idx;

    logic [SLICE-1:0] opa_sl;
    logic [SLICE-1:0] opb_sl;
    logic [SLICE:0]   sum;
    logic [SLICE-1:0] s;
    logic             c;
    logic             last;
    logic [WIDTH-1:0] b_lat;
    logic             c_lat;

    always_comb begin
        opa_sl = opa[idx*SLICE +: SLICE];
        opb_sl = opb[idx*SLICE +: SLICE];
        sum    = {1'b0, opa_sl} + {1'b0, opb_sl} + {{SLICE{1'b0}}, carry};
        s      = sum[SLICE-1:0];
        c      = sum[SLICE];
        last   = (idx == IW'(NSLICE - 1));
    end

`ifdef ADD_MODE_EN
    assign b_lat = op ? ~B : B;
    assign c_lat = op;
`else
    assign b_lat = ~B;
    assign c_lat = 1'b1;
`endif

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b0;
            idx    <= '0;
            out    <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= b_lat;
                        carry <= c_lat;
                        idx   <= '0;
                        zacc  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    out[idx*SLICE +: SLICE] <= s;
                    carry <= c;
                    zacc  <= zacc & (s == '0);
                    idx   <= idx + IW'(1);
                    if (last) begin
                        flag_n <= s[SLICE-1];
                        flag_z <= zacc & (s == '0);
                        flag_c <= c;
                        // opb holds the adder-side operand, so same-sign inputs means overflow is possible
                        flag_v <= ~(opa[WIDTH-1] ^ opb[WIDTH-1]) & (s[SLICE-1] ^ opa[WIDTH-1]);
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_64_mc.sv
// Scoreboard bench for subtractor_64_mc: expected results queued at issue, checked on done.
module tb_subtractor_64_mc;

    typedef struct packed {
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_sel;
    logic [63:0] A;
    logic [63:0] B;
    logic        busy;
    logic        done;
    logic [63:0] out;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    subtractor_64_mc dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
`ifdef ADD_MODE_EN
        .op     (op_sel),
`endif
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        exp_t e;
        logic [64:0] w;
        if (sub) begin
            e.r = a - b;
            e.c = (a >= b);
            e.v = (a[63] ^ b[63]) & (e.r[63] ^ a[63]);
        end else begin
            w   = {1'b0, a} + {1'b0, b};
            e.r = w[63:0];
            e.c = w[64];
            e.v = ~(a[63] ^ b[63]) & (e.r[63] ^ a[63]);
        end
        e.n = e.r[63];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            chk("busy_and_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", out, e.r);
                chk("flag_n", {63'd0, flag_n}, {63'd0, e.n});
                chk("flag_z", {63'd0, flag_z}, {63'd0, e.z});
                chk("flag_c", {63'd0, flag_c}, {63'd0, e.c});
                chk("flag_v", {63'd0, flag_v}, {63'd0, e.v});
            end
        end
    end

    // Called just after a negedge; the next posedge is the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub);
        A      = a;
        B      = b;
        op_sel = sub;
        start  = 1'b1;
        sb.push_back(model(a, b, sub));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 20);
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int n, nb;
        issue(a, b, sub);
        wait_done("done_seen", n, nb);
        chk("latency", 64'(n), 64'd5);
        chk("busy_cycles", 64'(nb), 64'd4);
    endtask

    initial begin
        int n, nb;
        reset  = 1'b0;
        start  = 1'b0;
        op_sel = 1'b1;
        A      = '0;
        B      = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_op(64'd5, 64'd3, 1'b1);
        do_op(64'd0, 64'd1, 1'b1);
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1);
        do_op(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
        do_op(64'h0000_0000_0001_0000, 64'd1, 1'b1);

        // start pulsed mid-RUN must be ignored
        issue(64'h1234_0000_0000_0000, 64'h0000_0000_0000_0042, 1'b1);
        @(negedge clk);
        A     = 64'hDEAD_BEEF_0000_0001;
        B     = 64'h0000_FFFF_FFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("mid_done", n, nb);

        // back-to-back accept from DONE
        issue(64'd10, 64'd4, 1'b1);
        wait_done("b2b_done", n, nb);
        chk("b2b_latency", 64'(n), 64'd5);

        // reset during the second RUN cycle
        issue(64'd7, 64'd2, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_out", out, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", {63'd0, done}, 64'd0);
        do_op(64'd9, 64'd9, 1'b1);

        for (int i = 0; i < 6; i++) begin
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        end

`ifdef ADD_MODE_EN
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/subtractor_64_mc.md
Name: subtractor_64_mc

Overview:
- Multi-cycle 64-bit subtract unit: the inverse operation of the CPU's 64-bit ripple adder.
- Computes A - B as A + ~B + 1, one SLICE-bit chunk per clock, LSB slice first, with the borrow/carry registered between slices.
- Produces ARM-style NZCV flags for SUBS/CMP.
- Sits beside the ALU for the multi-cycle datapath, using a start/busy/done handshake with the control FSM.

Parameters:
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE.
- SLICE, 16, bits processed per clock; NSLICE = WIDTH/SLICE (default 4).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request; sampled only when the unit is ready (IDLE or DONE)
- A  input  WIDTH  minuend; sampled on the accepting edge only
- B  input  WIDTH  subtrahend; sampled on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags valid
- out  output  WIDTH  result A - B, held until the next accepted start
- flag_n  output  1  out[WIDTH-1]
- flag_z  output  1  out == 0
- flag_c  output  1  carry out of MSB (1 = no borrow, ARM convention)
- flag_v  output  1  signed overflow

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, out=0, all flags 0.
  - Internal operand registers, slice index and carry are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 on an edge latches A into opa and ~B into opb, sets carry=1, idx=0, zacc=1, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - {c, s} = opa[idx slice] + opb[idx slice] + carry, computed at SLICE+1 bits.
  - Writes s into out[idx slice], then carry <= c and zacc <= zacc & (s == 0).
  - idx increments. The edge with idx == NSLICE-1 is the final slice and goes to DONE.
- Flags are registered on the final-slice edge:
  - flag_n = s[SLICE-1]; flag_z = zacc & (s == 0); flag_c = c.
  - flag_v = (opa_msb ^ b_msb) & (s[SLICE-1] ^ opa_msb), where b_msb is the original, un-inverted B MSB.
- DONE lasts exactly one cycle with done=1:
  - start=1 in DONE is accepted (back-to-back): same latch actions as in IDLE, then goes to RUN.
  - Otherwise returns to IDLE.
- Latency: the edge that samples start is edge 0; done is high during the cycle after edge NSLICE (4 cycles at default).
- Throughput: one operation every NSLICE+1 cycles, back-to-back via DONE.
- busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both high.
- start while busy: ignored. No re-latch, no effect on the in-flight operation.
- out changes only in RUN slices. Between operations it holds the last result.
- During RUN, out holds a mix of old and new slices: consumers use out only when done=1 or later.
- Reset mid-RUN: aborts immediately to the reset values above; no done pulse.
- Arithmetic is modulo 2^WIDTH. The borrow chain crosses slice boundaries only through the registered carry.

Optional Feature:
- Macro ADD_MODE_EN.
- Defined:
  - Adds port op (input, 1), sampled with start: 1 = subtract, 0 = add.
  - Add mode latches opb = B with carry=1'b0. flag_v uses the b_msb seen by the adder (B, not ~B) for the sign comparison.
  - flag_c = carry out; latency and handshake are unchanged.
- Not defined: no op port; the unit always subtracts.

Test Plan:
- Reset, then start with A=5, B=3 -> done after 4 cycles; out=2, N=0 Z=0 C=1 V=0; busy high for exactly 4 cycles.
- A=0, B=1 -> out=64'hFFFF_FFFF_FFFF_FFFF, N=1 Z=0 C=0 V=0.
- A=64'h8000_0000_0000_0000, B=1 -> out=64'h7FFF_FFFF_FFFF_FFFF, N=0 C=1 V=1.
- A=B=64'h0123_4567_89AB_CDEF -> out=0, Z=1 C=1. A=64'h0000_0000_0001_0000, B=1 -> out=64'h0000_0000_0000_FFFF, which checks the inter-slice borrow.
- start pulsed mid-RUN with new operands -> ignored, first result correct. start held during DONE with A=10, B=4 -> second op accepted, done 4 cycles later with out=6.
- reset asserted during the 2nd RUN cycle -> outputs 0 immediately, no done pulse. A fresh op after release (A=9, B=9) -> out=0, Z=1. With ADD_MODE_EN, op=0, A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> out=64'h8000_0000_0000_0000, N=1 V=1 C=0.
